// File: rtl/dcache_store_buffer.sv
// dcache_store_buffer
//   Write buffer between the MEM1 store-byte-enable logic and the single
//   DCache request port. Stores are captured into a circular FIFO, merged into
//   the youngest entry when they hit the same word, and drained in order.
//   Loads share the DCache port; a load whose word is still buffered is
//   flagged through ld_conflict so the pipeline stalls rather than reading
//   stale data.
//
// Ports
//   clk, resetn                 clock (rising edge), async active-low reset
//   st_valid/st_addr/st_wen/st_data -> st_ready
//                               store capture; accepted when st_valid & st_ready
//   ld_valid/ld_addr -> ld_conflict, ld_done
//                               load request (held until ld_done), conflict flag
//   sync_req -> drained         drain request; drained = empty and idle
//   dc_req/dc_wr/dc_addr/dc_wen/dc_wdata <- dc_ready
//                               DCache request port
module dcache_store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [3:0]  st_wen,
  input  logic [31:0] st_data,
  output logic        st_ready,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  output logic        ld_conflict,
  output logic        ld_done,
  input  logic        sync_req,
  output logic        drained,
  output logic        dc_req,
  output logic        dc_wr,
  output logic [31:0] dc_addr,
  output logic [3:0]  dc_wen,
  output logic [31:0] dc_wdata,
  input  logic        dc_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR,
    S_RD
  } state_t;

  state_t state_q, state_d;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0] head_q, tail_q, count;
  logic [AW-1:0] head_idx, tail_idx, young_idx;
  logic          full, empty;

  logic [29:0] waddr_q [DEPTH];
  logic [3:0]  wen_q   [DEPTH];
  logic [31:0] data_q  [DEPTH];

  logic st_fire, merge_ok, do_merge, do_push, do_pop;

  assign head_idx  = head_q[AW-1:0];
  assign tail_idx  = tail_q[AW-1:0];
  assign young_idx = tail_idx - AW'(1);
  assign count     = tail_q - head_q;
  assign empty     = (head_q == tail_q);
  assign full      = (head_idx == tail_idx) && (head_q[AW] != tail_q[AW]);

  // A full buffer refuses stores even when a pop happens in the same cycle.
  assign st_ready = ~full;
  assign st_fire  = st_valid & ~full;

  // The youngest entry may absorb a same-word store unless it is the head
  // currently presented to the DCache: that request must stay stable.
  assign merge_ok = ~empty && (waddr_q[young_idx] == st_addr[31:2]) &&
                    !((state_q == S_WR) && (count == PW'(1)));

  // Stores with no byte enabled are acknowledged and dropped.
  assign do_merge = st_fire & (|st_wen) & merge_ok;
  assign do_push  = st_fire & (|st_wen) & ~merge_ok;

  // Load conflict scan over every live entry, regardless of byte enables.
  always_comb begin
    ld_conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (({1'b0, AW'(i) - head_idx} < count) && (waddr_q[i] == ld_addr[31:2]))
        ld_conflict = 1'b1;
    end
  end

  // NOTE: the entry storage has no reset; only the pointers define which
  // entries are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      waddr_q[tail_idx] <= st_addr[31:2];
      wen_q[tail_idx]   <= st_wen;
      data_q[tail_idx]  <= st_data;
    end else if (do_merge) begin
      wen_q[young_idx] <= wen_q[young_idx] | st_wen;
      for (int b = 0; b < 4; b++) begin
        if (st_wen[b]) data_q[young_idx][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      state_q <= S_IDLE;
    end else begin
      if (do_push) tail_q <= tail_q + PW'(1);
      if (do_pop)  head_q <= head_q + PW'(1);
      state_q <= state_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    dc_req   = 1'b0;
    dc_wr    = 1'b0;
    dc_addr  = '0;
    dc_wen   = '0;
    dc_wdata = '0;
    ld_done  = 1'b0;
    do_pop   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Loads win unless the buffer is full or a drain is requested.
        if (ld_valid && !ld_conflict && !full && !sync_req) state_d = S_RD;
        else if (!empty)                                      state_d = S_WR;
      end
      S_WR: begin
        dc_req   = 1'b1;
        dc_wr    = 1'b1;
        dc_addr  = {waddr_q[head_idx], 2'b00};
        dc_wen   = wen_q[head_idx];
        dc_wdata = data_q[head_idx];
        if (dc_ready) begin
          do_pop  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        dc_req  = 1'b1;
        dc_addr = {ld_addr[31:2], 2'b00};
        if (dc_ready) begin
          ld_done = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign drained = empty && (state_q == S_IDLE);

endmodule

// File: tb/tb_dcache_store_buffer.sv
module tb_dcache_store_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        resetn;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [3:0]  st_wen;
  logic [31:0] st_data;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_conflict;
  logic        ld_done;
  logic        sync_req;
  logic        drained;
  logic        dc_req;
  logic        dc_wr;
  logic [31:0] dc_addr;
  logic [3:0]  dc_wen;
  logic [31:0] dc_wdata;
  logic        dc_ready;

  int tests_run    = 0;
  int tests_failed = 0;

  dcache_store_buffer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .st_valid   (st_valid),
    .st_addr    (st_addr),
    .st_wen     (st_wen),
    .st_data    (st_data),
    .st_ready   (st_ready),
    .ld_valid   (ld_valid),
    .ld_addr    (ld_addr),
    .ld_conflict(ld_conflict),
    .ld_done    (ld_done),
    .sync_req   (sync_req),
    .drained    (drained),
    .dc_req     (dc_req),
    .dc_wr      (dc_wr),
    .dc_addr    (dc_addr),
    .dc_wen     (dc_wen),
    .dc_wdata   (dc_wdata),
    .dc_ready   (dc_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the buffer is an ordered list of pending word writes,
  // and the port is either free, carrying the oldest write, or carrying the load.
  typedef struct {
    logic [29:0] waddr;
    logic [3:0]  wen;
    logic [31:0] data;
  } ent_t;
  typedef enum {P_NONE, P_WRITE, P_READ} port_t;

  task automatic idle_inputs();
    st_valid = 1'b0; st_addr = '0; st_wen = '0; st_data = '0;
    ld_valid = 1'b0; ld_addr = '0; sync_req = 1'b0; dc_ready = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle_inputs();
    #1;
    tests_run++; if (dc_req !== 1'b0) begin tests_failed++; $display("FAIL reset_dc_req got=%b exp=0", dc_req); end
    tests_run++; if (dc_wr !== 1'b0) begin tests_failed++; $display("FAIL reset_dc_wr got=%b exp=0", dc_wr); end
    tests_run++; if (dc_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_dc_addr got=%h exp=0", dc_addr); end
    tests_run++; if (dc_wen !== 4'h0) begin tests_failed++; $display("FAIL reset_dc_wen got=%h exp=0", dc_wen); end
    tests_run++; if (dc_wdata !== 32'h0) begin tests_failed++; $display("FAIL reset_dc_wdata got=%h exp=0", dc_wdata); end
    tests_run++; if (ld_done !== 1'b0) begin tests_failed++; $display("FAIL reset_ld_done got=%b exp=0", ld_done); end
    tests_run++; if (st_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_st_ready got=%b exp=1", st_ready); end
    tests_run++; if (drained !== 1'b1) begin tests_failed++; $display("FAIL reset_drained got=%b exp=1", drained); end
    tests_run++; if (ld_conflict !== 1'b0) begin tests_failed++; $display("FAIL reset_ld_conflict got=%b exp=0", ld_conflict); end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_store_drain();
    idle_inputs();
    dc_ready = 1'b1;
    st_valid = 1'b1; st_addr = 32'h100; st_wen = 4'hF; st_data = 32'hDEADBEEF;
    #1;
    tests_run++; if (st_ready !== 1'b1) begin tests_failed++; $display("FAIL sd_st_ready got=%b exp=1", st_ready); end
    tick();
    st_valid = 1'b0;
    #1;
    tests_run++; if (drained !== 1'b0) begin tests_failed++; $display("FAIL sd_not_drained got=%b exp=0", drained); end
    tick();
    #1;
    tests_run++; if ({dc_req, dc_wr} !== 2'b11) begin tests_failed++; $display("FAIL sd_req_wr got=%b exp=11", {dc_req, dc_wr}); end
    tests_run++; if (dc_addr !== 32'h100) begin tests_failed++; $display("FAIL sd_addr got=%h exp=00000100", dc_addr); end
    tests_run++; if (dc_wen !== 4'hF) begin tests_failed++; $display("FAIL sd_wen got=%h exp=f", dc_wen); end
    tests_run++; if (dc_wdata !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL sd_wdata got=%h exp=deadbeef", dc_wdata); end
    tick();
    #1;
    tests_run++; if (drained !== 1'b1) begin tests_failed++; $display("FAIL sd_drained got=%b exp=1", drained); end
    tests_run++; if (dc_req !== 1'b0) begin tests_failed++; $display("FAIL sd_req_after got=%b exp=0", dc_req); end
    @(negedge clk);
  endtask

  task automatic test_merge();
    idle_inputs();
    ld_valid = 1'b1; ld_addr = 32'h800;
    tick();
    #1;
    tests_run++; if ({dc_req, dc_wr} !== 2'b10 || dc_addr !== 32'h800) begin tests_failed++; $display("FAIL mg_hold_rd got=%b/%h exp=10/00000800", {dc_req, dc_wr}, dc_addr); end
    @(negedge clk);
    st_valid = 1'b1; st_addr = 32'h200; st_wen = 4'b0001; st_data = 32'h000000AA;
    tick();
    st_addr = 32'h201; st_wen = 4'b0100; st_data = 32'h00BB0000;
    tick();
    st_valid = 1'b0;
    dc_ready = 1'b1;
    #1;
    tests_run++; if (ld_done !== 1'b1) begin tests_failed++; $display("FAIL mg_ld_done got=%b exp=1", ld_done); end
    tick();
    ld_valid = 1'b0;
    #1;
    tests_run++; if (dc_req !== 1'b0) begin tests_failed++; $display("FAIL mg_idle got=%b exp=0", dc_req); end
    tick();
    #1;
    tests_run++; if ({dc_req, dc_wr} !== 2'b11 || dc_addr !== 32'h200) begin tests_failed++; $display("FAIL mg_wr got=%b/%h exp=11/00000200", {dc_req, dc_wr}, dc_addr); end
    tests_run++; if (dc_wen !== 4'b0101) begin tests_failed++; $display("FAIL mg_wen got=%b exp=0101", dc_wen); end
    tests_run++; if (dc_wdata !== 32'h00BB00AA) begin tests_failed++; $display("FAIL mg_wdata got=%h exp=00bb00aa", dc_wdata); end
    tick();
    #1;
    tests_run++; if (drained !== 1'b1) begin tests_failed++; $display("FAIL mg_single_entry drained=%b exp=1", drained); end
    @(negedge clk);
    dc_ready = 1'b0;
  endtask

  task automatic test_fill();
    logic [31:0] exp_data [5];
    logic [31:0] got_addr [$];
    logic [31:0] got_data [$];
    logic        accept;
    idle_inputs();
    for (int k = 0; k < 5; k++) exp_data[k] = $urandom;
    for (int k = 0; k < 4; k++) begin
      st_valid = 1'b1; st_addr = 32'h1000 + 32'(4 * k); st_wen = 4'hF; st_data = exp_data[k];
      tick();
    end
    st_addr = 32'h1010; st_data = exp_data[4];
    #1;
    tests_run++; if (st_ready !== 1'b0) begin tests_failed++; $display("FAIL fill_full got=%b exp=0", st_ready); end
    tick();
    #1;
    tests_run++; if (st_ready !== 1'b0) begin tests_failed++; $display("FAIL fill_still_full got=%b exp=0", st_ready); end
    @(negedge clk);
    dc_ready = 1'b1;
    for (int c = 0; c < 40 && got_addr.size() < 5; c++) begin
      #1;
      if (c == 0) begin
        tests_run++; if (st_ready !== 1'b0) begin tests_failed++; $display("FAIL fill_no_pushthrough got=%b exp=0", st_ready); end
      end
      if (dc_req && dc_wr) begin
        got_addr.push_back(dc_addr);
        got_data.push_back(dc_wdata);
      end
      accept = st_valid && st_ready;
      tick();
      if (accept) st_valid = 1'b0;
    end
    tests_run++; if (got_addr.size() != 5) begin tests_failed++; $display("FAIL fill_drain_count got=%0d exp=5", got_addr.size()); end
    for (int k = 0; k < 5 && k < got_addr.size(); k++) begin
      tests_run++;
      if (got_addr[k] !== 32'h1000 + 32'(4 * k) || got_data[k] !== exp_data[k]) begin
        tests_failed++;
        $display("FAIL fill_order[%0d] got=%h/%h exp=%h/%h", k, got_addr[k], got_data[k], 32'h1000 + 32'(4 * k), exp_data[k]);
      end
    end
    #1;
    tests_run++; if (drained !== 1'b1) begin tests_failed++; $display("FAIL fill_drained got=%b exp=1", drained); end
    @(negedge clk);
    dc_ready = 1'b0;
  endtask

  task automatic test_conflict();
    idle_inputs();
    st_valid = 1'b1; st_addr = 32'h300; st_wen = 4'hF; st_data = 32'h12345678;
    tick();
    st_valid = 1'b0;
    ld_valid = 1'b1; ld_addr = 32'h302;
    #1;
    tests_run++; if (ld_conflict !== 1'b1) begin tests_failed++; $display("FAIL cf_flag got=%b exp=1", ld_conflict); end
    tick();
    #1;
    tests_run++; if (ld_conflict !== 1'b1) begin tests_failed++; $display("FAIL cf_flag_wr_head got=%b exp=1", ld_conflict); end
    tests_run++; if ({dc_req, dc_wr} !== 2'b11 || dc_addr !== 32'h300) begin tests_failed++; $display("FAIL cf_wr_first got=%b/%h exp=11/00000300", {dc_req, dc_wr}, dc_addr); end
    tick();
    #1;
    tests_run++; if (dc_wr !== 1'b1) begin tests_failed++; $display("FAIL cf_wr_held got=%b exp=1", dc_wr); end
    dc_ready = 1'b1;
    tick();
    #1;
    tests_run++; if (dc_req !== 1'b0 || ld_conflict !== 1'b0) begin tests_failed++; $display("FAIL cf_cleared req/conf got=%b%b exp=00", dc_req, ld_conflict); end
    tick();
    #1;
    tests_run++; if ({dc_req, dc_wr} !== 2'b10 || dc_addr !== 32'h300 || dc_wen !== 4'h0) begin tests_failed++; $display("FAIL cf_rd got=%b/%h/%h exp=10/00000300/0", {dc_req, dc_wr}, dc_addr, dc_wen); end
    tests_run++; if (ld_done !== 1'b1) begin tests_failed++; $display("FAIL cf_ld_done got=%b exp=1", ld_done); end
    tick();
    ld_valid = 1'b0;
    #1;
    tests_run++; if (ld_done !== 1'b0) begin tests_failed++; $display("FAIL cf_ld_done_pulse got=%b exp=0", ld_done); end
    @(negedge clk);
    dc_ready = 1'b0;
  endtask

  task automatic test_priority();
    logic [31:0] wr_addr [$];
    int          rd_cnt;
    bit          seen;
    rd_cnt = 0;
    seen = 1'b0;
    idle_inputs();
    ld_valid = 1'b1; ld_addr = 32'h900;
    tick();
    st_valid = 1'b1; st_addr = 32'h400; st_wen = 4'hF; st_data = 32'h44;
    tick();
    st_addr = 32'h404; st_data = 32'h55;
    tick();
    st_valid = 1'b0;
    dc_ready = 1'b1;
    tick();
    ld_addr = 32'hA00;
    #1;
    tests_run++; if (dc_req !== 1'b0) begin tests_failed++; $display("FAIL pr_idle got=%b exp=0", dc_req); end
    tick();
    #1;
    tests_run++; if ({dc_req, dc_wr} !== 2'b10 || dc_addr !== 32'hA00 || ld_done !== 1'b1) begin tests_failed++; $display("FAIL pr_rd_first got=%b/%h/%b exp=10/00000a00/1", {dc_req, dc_wr}, dc_addr, ld_done); end
    tick();
    ld_addr = 32'hB00; sync_req = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (drained) begin seen = 1'b1; break; end
      if (dc_req) begin
        if (dc_wr) wr_addr.push_back(dc_addr);
        else rd_cnt++;
      end
      tick();
    end
    tests_run++; if (seen !== 1'b1) begin tests_failed++; $display("FAIL pr_sync_drained got=%b exp=1", seen); end
    tests_run++; if (rd_cnt != 0) begin tests_failed++; $display("FAIL pr_sync_no_rd got=%0d exp=0", rd_cnt); end
    tests_run++;
    if (wr_addr.size() != 2 || wr_addr[0] !== 32'h400 || wr_addr[1] !== 32'h404) begin
      tests_failed++;
      $display("FAIL pr_sync_writes got=%0d writes exp=2 (00000400,00000404)", wr_addr.size());
    end
    sync_req = 1'b0;
    tick();
    #1;
    tests_run++; if ({dc_req, dc_wr} !== 2'b10 || dc_addr !== 32'hB00 || ld_done !== 1'b1) begin tests_failed++; $display("FAIL pr_rd_after_sync got=%b/%h/%b exp=10/00000b00/1", {dc_req, dc_wr}, dc_addr, ld_done); end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    st_valid = 1'b1; st_addr = 32'h500; st_wen = 4'hF; st_data = 32'h5A5A5A5A;
    tick();
    st_valid = 1'b0;
    tick();
    #1;
    tests_run++; if ({dc_req, dc_wr} !== 2'b11) begin tests_failed++; $display("FAIL rm_in_wr got=%b exp=11", {dc_req, dc_wr}); end
    #1;
    resetn = 1'b0;
    ld_addr = 32'h500;
    #1;
    tests_run++; if (dc_req !== 1'b0 || dc_wr !== 1'b0) begin tests_failed++; $display("FAIL rm_req_cleared got=%b%b exp=00", dc_req, dc_wr); end
    tests_run++; if (st_ready !== 1'b1 || drained !== 1'b1) begin tests_failed++; $display("FAIL rm_empty ready/drained got=%b%b exp=11", st_ready, drained); end
    @(negedge clk);
    resetn = 1'b1;
    tick();
    #1;
    tests_run++; if (dc_req !== 1'b0 || drained !== 1'b1 || ld_conflict !== 1'b0) begin tests_failed++; $display("FAIL rm_discarded req/drained/conf got=%b%b%b exp=010", dc_req, drained, ld_conflict); end
    @(negedge clk);
  endtask

  task automatic test_random();
    ent_t        q [$];
    ent_t        e;
    port_t       port, port_n;
    bit          ld_active, exp_conf, exp_done, pop, merge, push;
    logic [31:0] exp_addr;
    idle_inputs();
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    port = P_NONE;
    ld_active = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      st_valid = ($urandom_range(0, 9) < 6);
      st_addr  = 32'h40 + 32'(4 * $urandom_range(0, 5)) + 32'($urandom_range(0, 3));
      st_wen   = 4'($urandom_range(0, 15));
      st_data  = $urandom;
      dc_ready = ((c / 200) % 2 == 1) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8);
      sync_req = ($urandom_range(0, 9) == 0);
      if (!ld_active && $urandom_range(0, 3) == 0) begin
        ld_active = 1'b1;
        ld_addr   = 32'h40 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      end else if (!ld_active) begin
        ld_addr = 32'h40 + 32'(4 * $urandom_range(0, 7));
      end
      ld_valid = ld_active;
      #1;
      exp_conf = 1'b0;
      foreach (q[i]) if (q[i].waddr == ld_addr[31:2]) exp_conf = 1'b1;
      exp_done = (port == P_READ) && dc_ready;
      tests_run++; if (st_ready !== (q.size() < DEPTH)) begin tests_failed++; $display("FAIL rnd_st_ready c=%0d got=%b exp=%b", c, st_ready, q.size() < DEPTH); end
      tests_run++; if (ld_conflict !== exp_conf) begin tests_failed++; $display("FAIL rnd_conflict c=%0d got=%b exp=%b", c, ld_conflict, exp_conf); end
      tests_run++; if (dc_req !== (port != P_NONE)) begin tests_failed++; $display("FAIL rnd_dc_req c=%0d got=%b exp=%b", c, dc_req, port != P_NONE); end
      tests_run++; if (ld_done !== exp_done) begin tests_failed++; $display("FAIL rnd_ld_done c=%0d got=%b exp=%b", c, ld_done, exp_done); end
      tests_run++; if (drained !== (q.size() == 0 && port == P_NONE)) begin tests_failed++; $display("FAIL rnd_drained c=%0d got=%b", c, drained); end
      if (port == P_WRITE) begin
        exp_addr = {q[0].waddr, 2'b00};
        tests_run++;
        if (dc_wr !== 1'b1 || dc_addr !== exp_addr || dc_wen !== q[0].wen || dc_wdata !== q[0].data) begin
          tests_failed++;
          $display("FAIL rnd_write c=%0d got=%b/%h/%h/%h exp=1/%h/%h/%h", c, dc_wr, dc_addr, dc_wen, dc_wdata, exp_addr, q[0].wen, q[0].data);
        end
      end else if (port == P_READ) begin
        exp_addr = {ld_addr[31:2], 2'b00};
        tests_run++;
        if (dc_wr !== 1'b0 || dc_addr !== exp_addr || dc_wen !== 4'h0) begin
          tests_failed++;
          $display("FAIL rnd_read c=%0d got=%b/%h/%h exp=0/%h/0", c, dc_wr, dc_addr, dc_wen, exp_addr);
        end
      end
      // Next-cycle behaviour of the reference.
      port_n = port;
      pop    = (port == P_WRITE) && dc_ready;
      if (port == P_NONE) begin
        if (ld_valid && !exp_conf && q.size() < DEPTH && !sync_req) port_n = P_READ;
        else if (q.size() > 0)                                      port_n = P_WRITE;
      end else if (dc_ready) begin
        port_n = P_NONE;
      end
      merge = 1'b0;
      push  = 1'b0;
      if (st_valid && q.size() < DEPTH && st_wen != 4'h0) begin
        if (q.size() > 0 && q[$].waddr == st_addr[31:2] && !(port == P_WRITE && q.size() == 1))
          merge = 1'b1;
        else
          push = 1'b1;
      end
      @(posedge clk);
      if (pop) void'(q.pop_front());
      if (merge) begin
        e = q[$];
        for (int b = 0; b < 4; b++) if (st_wen[b]) e.data[8*b +: 8] = st_data[8*b +: 8];
        e.wen = e.wen | st_wen;
        q[q.size() - 1] = e;
      end else if (push) begin
        e.waddr = st_addr[31:2];
        e.wen   = st_wen;
        e.data  = st_data;
        q.push_back(e);
      end
      port = port_n;
      if (exp_done) ld_active = 1'b0;
      @(negedge clk);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_store_drain();
    test_merge();
    test_fill();
    test_conflict();
    test_priority();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
